// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control unit.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// It drives the datapath muxes, ALU op and write enables, and waits on
// mem_ready when it talks to memory.
// Optional feature: define OVERFLOW_TRAP_EN to add the TRAP state and the
// exc_overflow output. Signed ALU ops that overflow then trap instead of
// writing back.
// MEM_WAIT_MAX: 0 waits on memory forever; 1..255 bounds each memory wait.
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       mem_timeout,
`ifdef OVERFLOW_TRAP_EN
  output logic       exc_overflow,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ILLEGAL  = 4'd10
`ifdef OVERFLOW_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  // Instruction class, captured in DECODE so the later states do not depend
  // on the IR still being stable.
  typedef enum logic [3:0] {
    C_R    = 4'd0,
    C_LW   = 4'd1,
    C_SW   = 4'd2,
    C_BEQ  = 4'd3,
    C_BNE  = 4'd4,
    C_J    = 4'd5,
    C_ADDI = 4'd6,
    C_ANDI = 4'd7,
    C_ILL  = 4'd8
  } cls_t;

  localparam logic [7:0] LP_WAIT_MAX = 8'(MEM_WAIT_MAX);
  localparam logic       LP_WAIT_EN  = (MEM_WAIT_MAX != 0);

  state_t     r_state;
  state_t     w_next;
  cls_t       r_cls;
  cls_t       w_cls;
  logic [1:0] r_rop;
  logic [1:0] w_rop;
  logic [7:0] r_wait_cnt;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_ovf_trap;
  logic       w_unused;

  // Decode opcode/funct into an instruction class and the R-type ALU op.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    w_cls = C_ILL;
    w_rop = 2'b01;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100100: begin w_cls = C_R; w_rop = 2'b00; end
          6'b100000: begin w_cls = C_R; w_rop = 2'b01; end
          6'b100010: begin w_cls = C_R; w_rop = 2'b10; end
          6'b100011: begin w_cls = C_R; w_rop = 2'b11; end
          default:   w_cls = C_ILL;
        endcase
      end
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: w_cls = C_BEQ;
      6'b000101: w_cls = C_BNE;
      6'b000010: w_cls = C_J;
      6'b001000: w_cls = C_ADDI;
      6'b001100: w_cls = C_ANDI;
      default:   w_cls = C_ILL;
    endcase
  end

  // A memory wait cycle, and the timeout that ends a wait that ran too long.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                      (r_state == S_MEM_WR)) && !mem_ready;
  assign w_timeout = LP_WAIT_EN && w_waiting && (r_wait_cnt == LP_WAIT_MAX);

`ifdef OVERFLOW_TRAP_EN
  // Only the signed arithmetic ops (ADD, SUB, RSUB, ADDI) can trap.
  assign w_ovf_trap = (r_state == S_ALU_WB) && overflow &&
                      (((r_cls == C_R) && (r_rop != 2'b00)) || (r_cls == C_ADDI));
  assign w_unused   = negative;
`else
  assign w_ovf_trap = 1'b0;
  assign w_unused   = negative ^ overflow;
`endif

  // State register, plus the instruction class captured in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cls   <= C_ILL;
      r_rop   <= 2'b01;
    end else begin
      // NOTE: state is written with non-blocking assignments, so every flop
      // samples values from before the clock edge.
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_cls;
        r_rop <= w_rop;
      end
    end
  end

  // Wait counter: cleared on any state change or timeout, and counts the
  // mem_ready=0 cycles in the memory states. It saturates so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if ((w_next != r_state) || w_timeout) begin
      r_wait_cnt <= 8'd0;
    end else if (w_waiting && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)      w_next = S_FETCH;
        else if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_cls)
          C_R, C_ADDI, C_ANDI: w_next = S_EXEC;
          C_LW, C_SW:          w_next = S_MEM_ADDR;
          C_BEQ, C_BNE:        w_next = S_BRANCH;
          C_J:                 w_next = S_JUMP;
          default:             w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC: w_next = S_ALU_WB;
      S_ALU_WB: begin
`ifdef OVERFLOW_TRAP_EN
        w_next = w_ovf_trap ? S_TRAP : S_FETCH;
`else
        w_next = S_FETCH;
`endif
      end
      S_MEM_ADDR: w_next = (r_cls == C_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (w_timeout)      w_next = S_FETCH;
        else if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: w_next = S_FETCH;
      S_MEM_WR: begin
        if (w_timeout || mem_ready) w_next = S_FETCH;
      end
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ILLEGAL: w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore outputs decoded from state. The only exceptions are the FETCH
  // writes gated by mem_ready, the branch pc_write gated by zero, and the
  // strobes dropped on timeout.
  always_comb begin
    alu_op      = 2'b01;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_zext    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    exc_overflow = 1'b0;
`endif
    // NOTE: the decode is gated by rst_n, so no strobe or write enable can
    // fire while reset is held, even though the reset state is FETCH.
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read    = !w_timeout;
          alu_src_b   = 2'b01;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
          mem_timeout = w_timeout;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_EXEC, S_ALU_WB: begin
          alu_src_a = 1'b1;
          case (r_cls)
            C_R:    begin alu_src_b = 2'b00; alu_op = r_rop; end
            C_ADDI: begin alu_src_b = 2'b10; alu_op = 2'b01; end
            C_ANDI: begin alu_src_b = 2'b10; alu_op = 2'b00; imm_zext = 1'b1; end
            default: ;
          endcase
          if (r_state == S_ALU_WB) begin
            reg_write = !w_ovf_trap;
            reg_dst   = (r_cls == C_R);
`ifdef OVERFLOW_TRAP_EN
            exc_overflow = w_ovf_trap;
`endif
          end
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read    = !w_timeout;
          iord        = 1'b1;
          mem_timeout = w_timeout;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write   = !w_timeout;
          iord        = 1'b1;
          mem_timeout = w_timeout;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          pc_src    = 2'b01;
          pc_write  = (r_cls == C_BNE) ? !zero : zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
        end
`ifdef OVERFLOW_TRAP_EN
        S_TRAP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main control unit. It is the initiator that drives the datapath ALU (ALUop, operand selects) and consumes the ALU's zero/negative/overflow flags.
- Sequences each instruction through fetch, decode, execute, memory and writeback, with a ready handshake toward memory.
- Sits between the instruction register and the datapath muxes and write enables.

Parameters:
- MEM_WAIT_MAX, 0: max cycles to wait for mem_ready. 0 = wait forever. Otherwise valid range is 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- negative  in  1  ALU negative flag
- overflow  in  1  ALU overflow flag
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  2  00 AND, 01 ADD, 10 A-B, 11 B-A
- alu_src_a  out  1  0 PC, 1 regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- imm_zext  out  1  zero-extend imm (ANDI)
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- illegal_op  out  1  one-cycle pulse on undecodable instruction
- mem_timeout  out  1  one-cycle pulse on memory wait timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: asynchronous on rst_n low → state FETCH. All enables, strobes and pulses are 0. alu_op=01, other selects 0. Reset mid-instruction aborts it; no write enable may fire in the reset cycle.
- Outputs are Moore (decoded from state), except gated enables noted below.
- Opcodes: 000000 R, 100011 LW, 101011 SW, 000100 BEQ, 000101 BNE, 000010 J, 001000 ADDI, 001100 ANDI.
- R funct: 100100→00, 100000→01, 100010→10, 100011→11. Any other funct is illegal.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=01. ir_write and pc_write (pc_src=00) are asserted only when mem_ready=1, then → DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=01 (branch target → ALUOut).
  - R/ADDI/ANDI → EXEC
  - LW/SW → MEM_ADDR
  - BEQ/BNE → BRANCH
  - J → JUMP
  - illegal opcode/funct → ILLEGAL
- EXEC: alu_src_a=1.
  - R: alu_src_b=00, alu_op from funct.
  - ADDI: alu_src_b=10, alu_op=01.
  - ANDI: alu_src_b=10, imm_zext=1, alu_op=00.
  - → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R else 0. alu_src_a/alu_src_b/alu_op held at EXEC values. → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=01. LW → MEM_RD, SW → MEM_WR.
- MEM_RD: mem_read=1, iord=1. On mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. → FETCH.
- MEM_WR: mem_write=1, iord=1. On mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=10, pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE, evaluated combinationally in the same cycle.
  - → FETCH.
- JUMP: pc_write=1, pc_src=10. → FETCH.
- ILLEGAL: illegal_op=1, no writes. → FETCH. PC has already advanced by 4.
- Latency (cycles, zero memory wait): R/ADDI/ANDI 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.
- Wait counter (8-bit):
  - Cleared on entering FETCH, MEM_RD or MEM_WR; increments each cycle mem_ready=0.
  - If MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX while still waiting: mem_timeout=1 for one cycle, strobes drop, state → FETCH.
  - A timeout in FETCH refetches from the same PC.
- mem_read and mem_write are never both 1. pc_write and reg_write are never asserted outside the states listed above.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined: adds state TRAP and output exc_overflow (1 bit).
  - In ALU_WB for R funct 100000/100010/100011 or ADDI: if overflow=1, reg_write is forced to 0, exc_overflow pulses 1 cycle, and the state goes ALU_WB → TRAP → FETCH.
  - TRAP: pc_write=1, pc_src=10 (vector driven externally).
  - ANDI/AND ignore overflow.
- Undefined: overflow is ignored, the result is written, and neither TRAP nor exc_overflow exists.

Test Plan:
- Reset mid-MEM_RD (assert rst_n=0) → state=FETCH immediately; reg_write and mem_read are 0 in the same cycle.
- R SUB (funct 100010), mem_ready always 1 → states FETCH, DECODE, EXEC, ALU_WB; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 only in cycle 4.
- LW with mem_ready low 3 cycles in MEM_RD → 8 cycles total; mem_read held high with iord=1 throughout MEM_RD; mem_to_reg=1 in MEM_WB.
- BEQ with zero=1 → pc_write=1, pc_src=01 in BRANCH. BNE with zero=1 → pc_write=0.
- opcode 111111 → illegal_op pulses in cycle 3; no reg_write or mem_write; next state FETCH.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in MEM_WR → mem_timeout pulses after 4 wait cycles; mem_write drops; state FETCH. With OVERFLOW_TRAP_EN, ADD 0x7FFFFFFF+1 → exc_overflow=1, reg_write=0, then TRAP.
